// File: rtl/spi_flash_reader_pkg.sv
// Shared constants, state encoding and byte-order helper for the SPI flash read path.
package spi_flash_reader_pkg;

  localparam logic [7:0] SPI_CMD_READ  = 8'h03;
  localparam int         SPI_XFER_BITS = 64;
  localparam int         ADDR_W        = 24;

  localparam int ST_IDLE_BIT    = 0;
  localparam int ST_RECOVER_BIT = 1;
  localparam int ST_SHIFT_BIT   = 2;
  localparam int ST_DONE_BIT    = 3;

  typedef enum logic [3:0] {
    IDLE    = 4'(1 << ST_IDLE_BIT),
    RECOVER = 4'(1 << ST_RECOVER_BIT),
    SHIFT   = 4'(1 << ST_SHIFT_BIT),
    DONE    = 4'(1 << ST_DONE_BIT)
  } state_t;

  // First byte on the wire lands in bits [31:24] of the receive register; it belongs in [7:0].
  function automatic logic [31:0] wire_to_word(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

endpackage

// File: rtl/spi_flash_reader_if.sv
// CPU-side read port of the flash reader.
interface spi_flash_reader_if;
  import spi_flash_reader_pkg::*;

  // rstrb is a one-cycle request taken only while rbusy is low; rbusy rises the cycle
  // after a taken request and falls together with the rdata update.
  logic              rstrb;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       rdata;
  logic              rbusy;

  modport master (output rstrb, output addr, input rdata, input rbusy);
  modport slave  (input rstrb, input addr, output rdata, output rbusy);

endinterface

// File: rtl/spi_tick_gen.sv
// SCLK half-period divider: one-cycle rise/fall enables, restarted by start.
module spi_tick_gen #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic en,
    output logic rise_tick,
    output logic fall_tick
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [CW-1:0] cnt;
    logic          phase;
    logic          wrap;

    assign wrap      = en && (cnt == CW'(CLK_DIV - 1));
    assign rise_tick = wrap && !phase;
    assign fall_tick = wrap && phase;

    always_ff @(posedge clk) begin
        if (!reset || start) begin
            cnt   <= '0;
            phase <= 1'b0;
        end else if (en) begin
            if (wrap) begin
                cnt   <= '0;
                phase <= ~phase;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/spi_flash_reader.sv
// Executes one SPI READ (0x03) per CPU word fetch and returns the assembled word.
module spi_flash_reader
    import spi_flash_reader_pkg::*;
#(
    parameter int CLK_DIV   = 2,
    parameter int ADDR_BITS = 24
) (
    input  logic               clk,
    input  logic               reset,
    spi_flash_reader_if.slave  bus,
    output logic               spi_cs_n,
    output logic               spi_clk,
    output logic               spi_mosi,
    input  logic               spi_miso,
    output state_t             state
);

    localparam int         REC_W     = $clog2(2 * CLK_DIV);
    localparam logic [6:0] LAST_HALF = 7'(2 * SPI_XFER_BITS - 1);

    state_t             state_q, state_d;
    logic [63:0]        shift_q;
    logic [63:0]        load_word;
    logic [31:0]        rx_q;
    logic [31:0]        rdata_q;
    logic [6:0]         bit_cnt;
    logic [REC_W-1:0]   rec_cnt;
    logic               pending;
    logic               rbusy_q, cs_n_q, sclk_q, mosi_q;
    logic               start, accept, first_bit;
    logic               rise_tick, fall_tick;
    logic               addr_unused;

    assign load_word   = {SPI_CMD_READ, bus.addr[ADDR_BITS-1:2], 2'b00, 32'h0};
    assign addr_unused = &bus.addr[1:0];
    assign first_bit   = (state_q == IDLE) ? load_word[63] : shift_q[63];

    assign bus.rdata = rdata_q;
    assign bus.rbusy = rbusy_q;
    assign spi_cs_n  = cs_n_q;
    assign spi_clk   = sclk_q;
    assign spi_mosi  = mosi_q;
    assign state     = state_q;

    spi_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .en        (state_q == SHIFT),
        .rise_tick (rise_tick),
        .fall_tick (fall_tick)
    );

    always_ff @(posedge clk) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        start   = 1'b0;
        accept  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.rstrb) begin
                    accept  = 1'b1;
                    start   = 1'b1;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (fall_tick && bit_cnt == LAST_HALF) state_d = DONE;
            end
            DONE: state_d = RECOVER;
            RECOVER: begin
                // A request arriving during deselect is held until the recovery time expires.
                accept = bus.rstrb && !pending;
                if (rec_cnt == REC_W'(2 * CLK_DIV - 1)) begin
                    if (pending || accept) begin
                        start   = 1'b1;
                        state_d = SHIFT;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            shift_q <= '0;
            rx_q    <= '0;
            rdata_q <= '0;
            bit_cnt <= '0;
            rec_cnt <= '0;
            pending <= 1'b0;
            rbusy_q <= 1'b0;
            cs_n_q  <= 1'b1;
            sclk_q  <= 1'b0;
            mosi_q  <= 1'b0;
        end else begin
            if (accept) begin
                shift_q <= load_word;
                rbusy_q <= 1'b1;
                pending <= 1'b1;
            end
            if (start) begin
                cs_n_q  <= 1'b0;
                sclk_q  <= 1'b0;
                mosi_q  <= first_bit;
                bit_cnt <= '0;
                pending <= 1'b0;
            end
            if (state_q == SHIFT) begin
                if (rise_tick || fall_tick) bit_cnt <= bit_cnt + 7'd1;
                if (rise_tick) begin
                    sclk_q <= 1'b1;
                    if (bit_cnt[6]) rx_q <= {rx_q[30:0], spi_miso};
                end
                if (fall_tick) begin
                    sclk_q  <= 1'b0;
                    shift_q <= {shift_q[62:0], 1'b0};
                    mosi_q  <= shift_q[62];
                    if (bit_cnt == LAST_HALF) cs_n_q <= 1'b1;
                end
            end
            if (state_q == DONE) begin
                rdata_q <= wire_to_word(rx_q);
                rbusy_q <= 1'b0;
            end
            rec_cnt <= (state_q == RECOVER) ? rec_cnt + REC_W'(1) : '0;
        end
    end

endmodule
